// File: rtl/ppu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// ppu_issue_ctrl
// Issue/completion controller for the PPU datapath. Every accepted legal op
// reserves the writeback slot L(op) cycles in the future in a shift-register
// scoreboard. The op code and tag travel down the scoreboard with the
// reservation and appear on the outputs in the cycle the result is due.
// Issue stalls only when the requested writeback slot is already taken.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   valid_i    in   op/tag_i offered this cycle
//   op         in   op code (ADD=0, SUB=1, MUL=2, DIV=3, others illegal)
//   tag_i      in   caller tag, returned with the result
//   flush_i    in   drop all in-flight ops and the op offered this cycle
//   stall_o    out  combinational; offered op not accepted, hold inputs
//   valid_o    out  registered; a result completes this cycle
//   op_o       out  registered; op code of the completing result
//   tag_o      out  registered; tag of the completing result
//   busy_o     out  registered; any op in flight (valid_o included)
//   illegal_o  out  registered; pulse, an illegal op was accepted last cycle
// ---------------------------------------------------------------------------
module ppu_issue_ctrl #(
   parameter int OP_SIZE = 3,
   parameter int TAG_W   = 4,
   parameter int LAT_ADD = 1,
   parameter int LAT_MUL = 2,
   parameter int LAT_DIV = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic [OP_SIZE-1:0] op,
   input  logic [TAG_W-1:0]   tag_i,
   input  logic               flush_i,
   output logic               stall_o,
   output logic               valid_o,
   output logic [OP_SIZE-1:0] op_o,
   output logic [TAG_W-1:0]   tag_o,
   output logic               busy_o,
   output logic               illegal_o
);

   localparam int LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
   localparam int LAT_MAX = (LAT_AM > LAT_DIV) ? LAT_AM : LAT_DIV;
   localparam int IDX_W   = (LAT_MAX < 1) ? 1 : $clog2(LAT_MAX + 1);

   logic [LAT_MAX:0]              occ_q, occ_d;
   logic [LAT_MAX:0][OP_SIZE-1:0] op_q, op_d;
   logic [LAT_MAX:0][TAG_W-1:0]   tag_q, tag_d;
   logic                          busy_q, busy_d;
   logic                          illegal_q, illegal_d;

   logic                          legal_s;
   logic [IDX_W-1:0]              lat_s;
   logic [IDX_W-1:0]              load_idx_s;
   logic                          accept_s;

   // Op decode: legality and the writeback latency of the offered op.
   always_comb begin
      legal_s = 1'b0;
      lat_s   = IDX_W'(LAT_ADD);
      case (op)
         OP_SIZE'(0), OP_SIZE'(1): begin
            legal_s = 1'b1;
            lat_s   = IDX_W'(LAT_ADD);
         end
         OP_SIZE'(2): begin
            legal_s = 1'b1;
            lat_s   = IDX_W'(LAT_MUL);
         end
         OP_SIZE'(3): begin
            legal_s = 1'b1;
            lat_s   = IDX_W'(LAT_DIV);
         end
         default: begin
            legal_s = 1'b0;
            lat_s   = IDX_W'(LAT_ADD);
         end
      endcase
      load_idx_s = lat_s - IDX_W'(1);
   end

   // occ_q[L] set means slot L is the one our load would shift into, so the
   // collision test reads only registered state and never stall_o itself.
   assign stall_o  = valid_i & legal_s & occ_q[lat_s] & ~flush_i;
   assign accept_s = valid_i & ~stall_o & ~flush_i;

   // Scoreboard next state: shift toward slot 0, then load the new reservation.
   always_comb begin
      occ_d = '0;
      op_d  = '0;
      tag_d = '0;
      for (int k = 0; k < LAT_MAX; k++) begin
         occ_d[k] = occ_q[k+1];
         op_d[k]  = op_q[k+1];
         tag_d[k] = tag_q[k+1];
      end
      if (flush_i) begin
         occ_d = '0;
      end else if (accept_s && legal_s) begin
         // the shifted-in bit here is occ_q[L], which is 0 whenever accept is set
         occ_d[load_idx_s] = 1'b1;
         op_d[load_idx_s]  = op;
         tag_d[load_idx_s] = tag_i;
      end else begin
         occ_d = occ_d;
      end
      busy_d    = |occ_d;
      illegal_d = accept_s & ~legal_s;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q     <= '0;
         op_q      <= '0;
         tag_q     <= '0;
         busy_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         occ_q     <= occ_d;
         op_q      <= op_d;
         tag_q     <= tag_d;
         busy_q    <= busy_d;
         illegal_q <= illegal_d;
      end
   end

   assign valid_o   = occ_q[0];
   assign op_o      = op_q[0];
   assign tag_o     = tag_q[0];
   assign busy_o    = busy_q;
   assign illegal_o = illegal_q;

endmodule

// File: tb/tb_ppu_issue_ctrl.sv
// Self-checking bench for ppu_issue_ctrl. The reference model keeps a list
// of pending results, each with the absolute cycle it is due in.
module tb_ppu_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid_i;
   logic [2:0] op;
   logic [3:0] tag_i;
   logic       flush_i;
   logic       stall_o, valid_o, busy_o, illegal_o;
   logic [2:0] op_o;
   logic [3:0] tag_o;

   ppu_issue_ctrl dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .op(op), .tag_i(tag_i),
      .flush_i(flush_i), .stall_o(stall_o), .valid_o(valid_o), .op_o(op_o),
      .tag_o(tag_o), .busy_o(busy_o), .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [2:0] op;
      logic [3:0] tag;
   } ent_t;

   ent_t pend[$];
   int   cyc;
   int   n_cmp;
   int   n_bad;
   logic exp_ill;
   logic after_rst;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int lat_of(input logic [2:0] o);
      if (o == 3'd2) return 2;
      if (o == 3'd3) return 3;
      return 1;
   endfunction

   // One clock cycle: check registered outputs, drive inputs, check stall,
   // let the edge happen and advance the model.
   task automatic step(input logic v, input logic [2:0] o, input logic [3:0] tg,
                       input logic fl, input logic r);
      logic       hit, legal, col, st;
      logic [2:0] eo;
      logic [3:0] et;
      int         lat;
      ent_t       keep[$];
      @(negedge clk);
      hit = 1'b0; eo = 3'd0; et = 4'd0;
      foreach (pend[i]) if (pend[i].due == cyc) begin
         hit = 1'b1; eo = pend[i].op; et = pend[i].tag;
      end
      check_eq("valid_o", {31'd0, valid_o}, {31'd0, hit});
      check_eq("busy_o", {31'd0, busy_o}, {31'd0, pend.size() != 0});
      check_eq("illegal_o", {31'd0, illegal_o}, {31'd0, exp_ill});
      if (hit || after_rst) begin
         check_eq("op_o", {29'd0, op_o}, {29'd0, eo});
         check_eq("tag_o", {28'd0, tag_o}, {28'd0, et});
      end
      valid_i = v; op = o; tag_i = tg; flush_i = fl; rst = r;
      #1;
      legal = (o <= 3'd3);
      lat   = lat_of(o);
      col   = 1'b0;
      foreach (pend[i]) if (pend[i].due == cyc + lat) col = 1'b1;
      st = v & legal & col & ~fl;
      check_eq("stall_o", {31'd0, stall_o}, {31'd0, st});
      @(posedge clk);
      if (r) begin
         pend.delete();
         exp_ill   = 1'b0;
         after_rst = 1'b1;
      end else begin
         after_rst = 1'b0;
         foreach (pend[i]) if (pend[i].due > cyc) keep.push_back(pend[i]);
         pend = keep;
         if (fl) pend.delete();
         else if (v && !st && legal) pend.push_back('{cyc + lat, o, tg});
         exp_ill = v & ~fl & ~legal;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0;
      valid_i = 1'b0; op = 3'd0; tag_i = 4'd0; flush_i = 1'b0; rst = 1'b1;
      repeat (2) @(posedge clk);
      exp_ill = 1'b0; after_rst = 1'b1;
      // reset state, then lone ADD
      idle(3);
      step(1'b1, 3'd0, 4'd5, 1'b0, 1'b0);
      idle(3);
      // DIV then MUL colliding on the same writeback slot
      step(1'b1, 3'd3, 4'd1, 1'b0, 1'b0);
      step(1'b1, 3'd2, 4'd2, 1'b0, 1'b0);
      step(1'b1, 3'd2, 4'd2, 1'b0, 1'b0);
      idle(4);
      // ADD stream, tags wrapping
      for (int i = 0; i < 20; i++) step(1'b1, 3'd0, 4'(i), 1'b0, 1'b0);
      idle(3);
      // flush with ops in flight
      step(1'b1, 3'd3, 4'd7, 1'b0, 1'b0);
      step(1'b1, 3'd3, 4'd8, 1'b0, 1'b0);
      step(1'b1, 3'd2, 4'd9, 1'b1, 1'b0);
      idle(4);
      // illegal op
      step(1'b1, 3'd5, 4'd3, 1'b0, 1'b0);
      idle(3);
      // reset mid-flight
      step(1'b1, 3'd3, 4'd6, 1'b0, 1'b0);
      step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
      step(1'b0, 3'd0, 4'd0, 1'b0, 1'b1);
      idle(4);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), 4'($urandom),
              $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
      end
      idle(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
